// File: rtl/controla_entrada.sv
// controla_entrada: user-side end of the CPU input-wait handshake.
// While bloq_cpu is high it waits for a debounced press of the confirm button.
// On a valid press it latches chaves into dado_entrada and pulses READY once.
// A press must be fully released (debounced low) before another READY is possible.
module controla_entrada #(
  parameter int DATA_W          = 8,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset,        // asynchronous, active-low
  input  logic              bloq_cpu,
  input  logic              botao,
  input  logic [DATA_W-1:0] chaves,
  output logic              READY,
  output logic [DATA_W-1:0] dado_entrada,
  output logic              aguardando
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_DEBOUNCE,
    S_ACK,
    S_RELEASE
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic              r_sync1;
  logic              r_sync2;
  logic [1:0]        r_warm;
  logic              w_btn_s;
  logic              w_sync_ok;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_next;
  logic [CNT_W-1:0]  w_cnt_inc;
  logic              w_ack_entry;
  logic              r_ready;
  logic [DATA_W-1:0] r_dado;
  logic              r_aguard;

  assign w_btn_s   = r_sync2;
  // The synchronizer is cleared by reset, so its output reads 0 for two
  // cycles after release even if the button is held. r_warm marks when
  // btn_s reflects the real pin again, so a button held through reset
  // is not mistaken for a release followed by a fresh press.
  assign w_sync_ok = r_warm[1];
  // Saturating increment; the counter never wraps.
  assign w_cnt_inc = (r_cnt == CNT_LIM) ? r_cnt : r_cnt + CNT_ONE;

  // Two-flop synchronizer for the push button plus warm-up tracker.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_warm  <= 2'b00;
    end else begin
      r_sync1 <= botao;
      r_sync2 <= r_sync1;
      r_warm  <= {r_warm[0], 1'b1};
    end
  end

  // Next-state and counter logic for the handshake FSM.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      S_IDLE: begin
        w_cnt_next = '0;
        if (bloq_cpu && w_sync_ok && !w_btn_s)
          w_state_next = S_ARMED;
      end
      S_ARMED: begin
        w_cnt_next = '0;
        if (!bloq_cpu) begin
          w_state_next = S_IDLE;
        end else if (w_btn_s) begin
          w_state_next = S_DEBOUNCE;
          w_cnt_next   = CNT_ONE;
        end
      end
      S_DEBOUNCE: begin
        if (!bloq_cpu) begin
          w_state_next = S_IDLE;
          w_cnt_next   = '0;
        end else if (!w_btn_s) begin
          w_state_next = S_ARMED;
          w_cnt_next   = '0;
        end else if (r_cnt == CNT_LIM) begin
          w_state_next = S_ACK;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = w_cnt_inc;
        end
      end
      S_ACK: begin
        w_state_next = S_RELEASE;
        w_cnt_next   = '0;
      end
      S_RELEASE: begin
        // bloq_cpu is deliberately ignored: the press must end first.
        if (w_btn_s) begin
          w_cnt_next = '0;
        end else if (r_cnt == CNT_LIM) begin
          w_state_next = S_IDLE;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = w_cnt_inc;
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  assign w_ack_entry = (r_state == S_DEBOUNCE) && (w_state_next == S_ACK);

  // State, counter and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_ready  <= 1'b0;
      r_dado   <= '0;
      r_aguard <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_cnt    <= w_cnt_next;
      r_ready  <= w_ack_entry;
      r_aguard <= (w_state_next == S_ARMED) || (w_state_next == S_DEBOUNCE);
      if (w_ack_entry)
        r_dado <= chaves;
    end
  end

  assign READY        = r_ready;
  assign dado_entrada = r_dado;
  assign aguardando   = r_aguard;

endmodule

// File: tb/tb_controla_entrada.sv
// Directed bench for controla_entrada with DATA_W=8, DEBOUNCE_CYCLES=4.
module tb_controla_entrada;

  logic       clk;
  logic       reset;
  logic       bloq_cpu;
  logic       botao;
  logic [7:0] chaves;
  logic       READY;
  logic [7:0] dado_entrada;
  logic       aguardando;

  int n_total;
  int n_pass;
  int n_fail;
  int ready_cnt;
  int cnt0;

  controla_entrada #(
    .DATA_W(8),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bloq_cpu(bloq_cpu),
    .botao(botao),
    .chaves(chaves),
    .READY(READY),
    .dado_entrada(dado_entrada),
    .aguardando(aguardando)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count cycles in which READY is high, sampled mid-cycle.
  always @(negedge clk) begin
    if (READY === 1'b1) ready_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_total = 0; n_pass = 0; n_fail = 0; ready_cnt = 0;
    reset = 1'b0; bloq_cpu = 1'b1; botao = 1'b1; chaves = 8'h00;

    // 1: reset with button held and CPU blocked
    tick(3);
    check("rst_ready", {31'b0, READY}, 32'd0);
    check("rst_dado", {24'b0, dado_entrada}, 32'h00);
    check("rst_aguard", {31'b0, aguardando}, 32'd0);
    reset = 1'b1;
    cnt0 = ready_cnt;
    tick(20);
    check("held_after_rst_no_ready", ready_cnt, cnt0);
    check("held_after_rst_idle", {31'b0, aguardando}, 32'd0);
    botao = 1'b0;
    tick(4);
    check("armed_aguard", {31'b0, aguardando}, 32'd1);

    // 2: normal handshake, READY 7 clocks after botao rises
    chaves = 8'hA5;
    botao = 1'b1;
    cnt0 = ready_cnt;
    tick(6);
    check("norm_ready_early", {31'b0, READY}, 32'd0);
    check("norm_aguard_debounce", {31'b0, aguardando}, 32'd1);
    tick(1);
    check("norm_ready_at7", {31'b0, READY}, 32'd1);
    check("norm_dado", {24'b0, dado_entrada}, 32'hA5);
    check("norm_aguard_fall", {31'b0, aguardando}, 32'd0);
    tick(1);
    check("norm_ready_one_cycle", {31'b0, READY}, 32'd0);
    bloq_cpu = 1'b0;
    botao = 1'b0;
    tick(10);
    check("norm_ready_count", ready_cnt, cnt0 + 1);

    // 3: bounce with short high runs, then a steady press
    bloq_cpu = 1'b1;
    chaves = 8'h3C;
    tick(5);
    cnt0 = ready_cnt;
    for (int h = 1; h <= 3; h++) begin
      botao = 1'b1;
      tick(h);
      botao = 1'b0;
      tick(3);
    end
    check("bounce_no_ready", ready_cnt, cnt0);
    check("bounce_dado_kept", {24'b0, dado_entrada}, 32'hA5);
    botao = 1'b1;
    tick(10);
    check("bounce_steady_one_ready", ready_cnt, cnt0 + 1);
    check("bounce_dado", {24'b0, dado_entrada}, 32'h3C);
    bloq_cpu = 1'b0;
    botao = 1'b0;
    tick(10);

    // 4: abort while debouncing
    bloq_cpu = 1'b1;
    chaves = 8'h11;
    tick(5);
    cnt0 = ready_cnt;
    botao = 1'b1;
    tick(4);
    check("abort_in_debounce", {31'b0, aguardando}, 32'd1);
    bloq_cpu = 1'b0;
    tick(1);
    check("abort_idle", {31'b0, aguardando}, 32'd0);
    tick(10);
    check("abort_no_ready", ready_cnt, cnt0);
    check("abort_dado_kept", {24'b0, dado_entrada}, 32'h3C);
    botao = 1'b0;
    tick(3);
    bloq_cpu = 1'b1;
    chaves = 8'h5A;
    tick(5);
    cnt0 = ready_cnt;
    botao = 1'b1;
    tick(7);
    check("abort_retry_ready", {31'b0, READY}, 32'd1);
    check("abort_retry_dado", {24'b0, dado_entrada}, 32'h5A);

    // 5: long press, CPU re-blocks 2 cycles after READY
    bloq_cpu = 1'b0;
    chaves = 8'hEE;
    tick(2);
    bloq_cpu = 1'b1;
    tick(41);
    check("long_press_one_ready", ready_cnt, cnt0 + 1);
    check("long_press_dado", {24'b0, dado_entrada}, 32'h5A);
    botao = 1'b0;
    tick(2);
    botao = 1'b1;
    tick(15);
    check("short_release_no_ready", ready_cnt, cnt0 + 1);
    botao = 1'b0;
    tick(10);
    check("release_rearmed", {31'b0, aguardando}, 32'd1);
    chaves = 8'hC3;
    botao = 1'b1;
    tick(7);
    check("second_press_ready", {31'b0, READY}, 32'd1);
    check("second_press_dado", {24'b0, dado_entrada}, 32'hC3);

    // 6: reset on the READY cycle
    reset = 1'b0;
    #1;
    check("rst_ack_ready", {31'b0, READY}, 32'd0);
    check("rst_ack_dado", {24'b0, dado_entrada}, 32'h00);
    check("rst_ack_aguard", {31'b0, aguardando}, 32'd0);
    tick(2);
    reset = 1'b1;
    cnt0 = ready_cnt;
    tick(20);
    check("rst_ack_no_second", ready_cnt, cnt0);
    botao = 1'b0;
    tick(10);
    chaves = 8'h77;
    botao = 1'b1;
    tick(7);
    check("rst_ack_new_ready", {31'b0, READY}, 32'd1);
    check("rst_ack_new_dado", {24'b0, dado_entrada}, 32'h77);
    tick(2);
    check("rst_ack_new_count", ready_cnt, cnt0 + 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
